// File: rtl/raifes_alu_arbiter_pkg.sv
// Shared ALU op codes, widths and arbiter constants.
// Used by raifes_alu and raifes_alu_arbiter.
package raifes_alu_arbiter_pkg;

    localparam int XPR_LEN      = 32;
    localparam int ALU_OP_WIDTH = 5;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD  = 5'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL  = 5'd1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR  = 5'd4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL  = 5'd5;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR   = 5'd6;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND  = 5'd7;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SEQ  = 5'd8;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SNE  = 5'd9;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB  = 5'd10;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA  = 5'd11;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT  = 5'd12;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SGE  = 5'd13;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLTU = 5'd14;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SGEU = 5'd15;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    localparam logic REQ_0 = 1'b0;
    localparam logic REQ_1 = 1'b1;

    typedef struct packed {
        logic [ALU_OP_WIDTH-1:0] op;
        logic [XPR_LEN-1:0]      in1;
        logic [XPR_LEN-1:0]      in2;
    } alu_req_t;

endpackage

// File: rtl/raifes_alu_arbiter_alu.sv
// raifes_alu: purely combinational integer ALU.
// Unknown op codes produce zero.
module raifes_alu
    import raifes_alu_arbiter_pkg::*;
(
    input  logic [ALU_OP_WIDTH-1:0] op,
    input  logic [XPR_LEN-1:0]      in1,
    input  logic [XPR_LEN-1:0]      in2,
    output logic [XPR_LEN-1:0]      out
);

    logic [4:0] shamt;
    logic       lt_s;
    logic       lt_u;

    assign shamt = in2[4:0];
    assign lt_s  = $signed(in1) < $signed(in2);
    assign lt_u  = in1 < in2;

    // Operation select; comparisons return a zero-extended flag
    always_comb begin
        out = '0;
        case (op)
            ALU_OP_ADD:  out = in1 + in2;
            ALU_OP_SLL:  out = in1 << shamt;
            ALU_OP_XOR:  out = in1 ^ in2;
            ALU_OP_SRL:  out = in1 >> shamt;
            ALU_OP_OR:   out = in1 | in2;
            ALU_OP_AND:  out = in1 & in2;
            ALU_OP_SEQ:  out = {31'b0, in1 == in2};
            ALU_OP_SNE:  out = {31'b0, in1 != in2};
            ALU_OP_SUB:  out = in1 - in2;
            ALU_OP_SRA:  out = $unsigned($signed(in1) >>> shamt);
            ALU_OP_SLT:  out = {31'b0, lt_s};
            ALU_OP_SGE:  out = {31'b0, !lt_s};
            ALU_OP_SLTU: out = {31'b0, lt_u};
            ALU_OP_SGEU: out = {31'b0, !lt_u};
            default:     out = '0;
        endcase
    end

endmodule

// File: rtl/raifes_alu_arbiter.sv
// Two-requester arbiter around one shared ALU with a registered result slot.
// RAIFES_ALU_ARB_RR_EN selects round-robin; default is fixed priority (req 0).
module raifes_alu_arbiter
    import raifes_alu_arbiter_pkg::*;
(
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    req_valid_0,
    output logic                    req_ready_0,
    input  logic [ALU_OP_WIDTH-1:0] req_op_0,
    input  logic [XPR_LEN-1:0]      req_in1_0,
    input  logic [XPR_LEN-1:0]      req_in2_0,
    output logic                    resp_valid_0,
    input  logic                    resp_ready_0,
    input  logic                    req_valid_1,
    output logic                    req_ready_1,
    input  logic [ALU_OP_WIDTH-1:0] req_op_1,
    input  logic [XPR_LEN-1:0]      req_in1_1,
    input  logic [XPR_LEN-1:0]      req_in2_1,
    output logic                    resp_valid_1,
    input  logic                    resp_ready_1,
    output logic [XPR_LEN-1:0]      resp_data,
    output logic                    busy
);

    arb_state_e         state_q;
    arb_state_e         state_d;
    logic               owner_q;
    logic [XPR_LEN-1:0] data_q;
    logic               owner_rdy;
    logic               slot_free;
    logic               grant_any;
    logic               win;
    alu_req_t           sel;
    logic [XPR_LEN-1:0] alu_out;

`ifdef RAIFES_ALU_ARB_RR_EN
    logic ptr_q;
`endif

    // Pick a winner among valid requesters
    always_comb begin
        win = REQ_0;
        if (req_valid_0 && req_valid_1) begin
`ifdef RAIFES_ALU_ARB_RR_EN
            win = ptr_q;
`else
            win = REQ_0;
`endif
        end else if (req_valid_1) begin
            win = REQ_1;
        end
    end

    assign owner_rdy = (owner_q == REQ_1) ? resp_ready_1
                                          : resp_ready_0;
    assign slot_free = nreset &&
                       ((state_q == ARB_IDLE) || owner_rdy);
    assign grant_any = slot_free &&
                       (req_valid_0 || req_valid_1);

    assign req_ready_0 = grant_any && (win == REQ_0);
    assign req_ready_1 = grant_any && (win == REQ_1);

    assign sel = (win == REQ_1)
               ? '{op: req_op_1, in1: req_in1_1, in2: req_in2_1}
               : '{op: req_op_0, in1: req_in1_0, in2: req_in2_0};

    raifes_alu u_alu (
        .op  (sel.op),
        .in1 (sel.in1),
        .in2 (sel.in2),
        .out (alu_out)
    );

    // Next state: a grant always refills the slot, else a drain empties it
    always_comb begin
        state_d = state_q;
        if (grant_any) begin
            state_d = ARB_HOLD;
        end else if (slot_free) begin
            state_d = ARB_IDLE;
        end
    end

    // Slot registers: state, owner and captured result
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ARB_IDLE;
            owner_q <= REQ_0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant_any) begin
                owner_q <= win;
                data_q  <= alu_out;
            end
        end
    end

`ifdef RAIFES_ALU_ARB_RR_EN
    // Favour the requester that was not granted last
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ptr_q <= REQ_0;
        end else if (grant_any) begin
            ptr_q <= ~win;
        end
    end
`endif

    assign busy         = (state_q == ARB_HOLD);
    assign resp_valid_0 = busy && (owner_q == REQ_0);
    assign resp_valid_1 = busy && (owner_q == REQ_1);
    assign resp_data    = data_q;

endmodule

// File: tb/tb_raifes_alu_arbiter.sv
// Directed self-checking bench for raifes_alu_arbiter.
// Contention section follows RAIFES_ALU_ARB_RR_EN.
module tb_raifes_alu_arbiter;
    import raifes_alu_arbiter_pkg::*;

    logic        clk;
    logic        nreset;
    logic        req_valid_0, req_valid_1;
    logic        req_ready_0, req_ready_1;
    logic [4:0]  req_op_0, req_op_1;
    logic [31:0] req_in1_0, req_in2_0;
    logic [31:0] req_in1_1, req_in2_1;
    logic        resp_valid_0, resp_valid_1;
    logic        resp_ready_0, resp_ready_1;
    logic [31:0] resp_data;
    logic        busy;

    int passed = 0;
    int total  = 0;

    raifes_alu_arbiter dut (
        .clk          (clk),
        .nreset       (nreset),
        .req_valid_0  (req_valid_0),
        .req_ready_0  (req_ready_0),
        .req_op_0     (req_op_0),
        .req_in1_0    (req_in1_0),
        .req_in2_0    (req_in2_0),
        .resp_valid_0 (resp_valid_0),
        .resp_ready_0 (resp_ready_0),
        .req_valid_1  (req_valid_1),
        .req_ready_1  (req_ready_1),
        .req_op_1     (req_op_1),
        .req_in1_1    (req_in1_1),
        .req_in2_1    (req_in2_1),
        .resp_valid_1 (resp_valid_1),
        .resp_ready_1 (resp_ready_1),
        .resp_data    (resp_data),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h",
                    tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        nreset       = 1'b0;
        req_valid_0  = 1'b0;
        req_valid_1  = 1'b0;
        req_op_0     = '0;
        req_op_1     = '0;
        req_in1_0    = '0;
        req_in2_0    = '0;
        req_in1_1    = '0;
        req_in2_1    = '0;
        resp_ready_0 = 1'b0;
        resp_ready_1 = 1'b0;

        #3;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_rv0", {31'b0, resp_valid_0}, 32'd0);
        check("rst_rv1", {31'b0, resp_valid_1}, 32'd0);
        check("rst_rr0", {31'b0, req_ready_0}, 32'd0);
        check("rst_data", resp_data, 32'd0);
        tick();
        nreset = 1'b1;
        tick();

        // single request: ADD 5+7
        req_valid_0 = 1'b1;
        req_op_0    = ALU_OP_ADD;
        req_in1_0   = 32'd5;
        req_in2_0   = 32'd7;
        #1;
        check("add_rr0", {31'b0, req_ready_0}, 32'd1);
        check("add_rr1", {31'b0, req_ready_1}, 32'd0);
        tick();
        req_valid_0 = 1'b0;
        #1;
        check("add_rv0", {31'b0, resp_valid_0}, 32'd1);
        check("add_rv1", {31'b0, resp_valid_1}, 32'd0);
        check("add_data", resp_data, 32'd12);
        check("add_busy", {31'b0, busy}, 32'd1);
        resp_ready_0 = 1'b1;
        tick();
        resp_ready_0 = 1'b0;
        #1;
        check("add_idle", {31'b0, busy}, 32'd0);
        check("add_rv0_off", {31'b0, resp_valid_0}, 32'd0);

        // unknown op 0x1F from requester 1
        req_valid_1 = 1'b1;
        req_op_1    = 5'h1F;
        req_in1_1   = 32'd3;
        req_in2_1   = 32'd4;
        #1;
        check("unk_rr1", {31'b0, req_ready_1}, 32'd1);
        tick();
        req_valid_1 = 1'b0;
        #1;
        check("unk_rv1", {31'b0, resp_valid_1}, 32'd1);
        check("unk_data", resp_data, 32'd0);
        resp_ready_1 = 1'b1;
        tick();
        resp_ready_1 = 1'b0;
        #1;
        check("unk_idle", {31'b0, busy}, 32'd0);

        // back-pressure: owner 0 stalls, req1 waits
        req_valid_0 = 1'b1;
        req_op_0    = ALU_OP_SUB;
        req_in1_0   = 32'd10;
        req_in2_0   = 32'd3;
        #1;
        check("bp_rr0", {31'b0, req_ready_0}, 32'd1);
        tick();
        req_valid_0  = 1'b0;
        req_valid_1  = 1'b1;
        req_op_1     = ALU_OP_OR;
        req_in1_1    = 32'h30;
        req_in2_1    = 32'h03;
        resp_ready_1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_rr1_low", {31'b0, req_ready_1}, 32'd0);
            check("bp_data", resp_data, 32'd7);
            check("bp_rv0", {31'b0, resp_valid_0}, 32'd1);
            tick();
        end
        resp_ready_0 = 1'b1;
        #1;
        check("bp_rr1_rel", {31'b0, req_ready_1}, 32'd1);
        tick();
        req_valid_1  = 1'b0;
        resp_ready_0 = 1'b0;
        resp_ready_1 = 1'b0;
        #1;
        check("bp_rv1", {31'b0, resp_valid_1}, 32'd1);
        check("bp_rv0_off", {31'b0, resp_valid_0}, 32'd0);
        check("bp_data1", resp_data, 32'h33);
        check("bp_busy", {31'b0, busy}, 32'd1);
        resp_ready_1 = 1'b1;
        tick();
        resp_ready_1 = 1'b0;
        #1;
        check("bp_idle", {31'b0, busy}, 32'd0);

`ifdef RAIFES_ALU_ARB_RR_EN
        // round-robin contention from reset
        nreset = 1'b0;
        #1;
        nreset = 1'b1;
        req_valid_0 = 1'b1;
        req_op_0    = ALU_OP_SUB;
        req_in1_0   = 32'd10;
        req_in2_0   = 32'd3;
        req_valid_1 = 1'b1;
        req_op_1    = ALU_OP_XOR;
        req_in1_1   = 32'hF0;
        req_in2_1   = 32'h0F;
        #1;
        check("rr_g0_rr0", {31'b0, req_ready_0}, 32'd1);
        check("rr_g0_rr1", {31'b0, req_ready_1}, 32'd0);
        tick();
        resp_ready_0 = 1'b1;
        #1;
        check("rr_rv0", {31'b0, resp_valid_0}, 32'd1);
        check("rr_data0", resp_data, 32'd7);
        check("rr_g1_rr1", {31'b0, req_ready_1}, 32'd1);
        check("rr_g1_rr0", {31'b0, req_ready_0}, 32'd0);
        tick();
        req_valid_0  = 1'b0;
        req_valid_1  = 1'b0;
        resp_ready_0 = 1'b0;
        #1;
        check("rr_rv1", {31'b0, resp_valid_1}, 32'd1);
        check("rr_data1", resp_data, 32'hFF);
        resp_ready_1 = 1'b1;
        tick();
        resp_ready_1 = 1'b0;
`else
        // fixed priority: req0 streams, req1 starves
        req_valid_0  = 1'b1;
        req_op_0     = ALU_OP_ADD;
        req_in1_0    = 32'd1;
        req_in2_0    = 32'd1;
        req_valid_1  = 1'b1;
        req_op_1     = ALU_OP_AND;
        req_in1_1    = 32'hFF00;
        req_in2_1    = 32'h0FF0;
        resp_ready_0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("fp_rr0", {31'b0, req_ready_0}, 32'd1);
            check("fp_rr1", {31'b0, req_ready_1}, 32'd0);
            tick();
        end
        check("fp_data0", resp_data, 32'd2);
        req_valid_0 = 1'b0;
        #1;
        check("fp_rr1_go", {31'b0, req_ready_1}, 32'd1);
        tick();
        req_valid_1  = 1'b0;
        resp_ready_0 = 1'b0;
        #1;
        check("fp_rv1", {31'b0, resp_valid_1}, 32'd1);
        check("fp_data1", resp_data, 32'h0F00);
        resp_ready_1 = 1'b1;
        tick();
        resp_ready_1 = 1'b0;
`endif
        #1;
        check("ct_idle", {31'b0, busy}, 32'd0);

        // reset while holding SLT -1 < 1
        req_valid_0 = 1'b1;
        req_op_0    = ALU_OP_SLT;
        req_in1_0   = 32'hFFFF_FFFF;
        req_in2_0   = 32'd1;
        tick();
        req_valid_0 = 1'b0;
        #1;
        check("slt_rv0", {31'b0, resp_valid_0}, 32'd1);
        check("slt_data", resp_data, 32'd1);
        nreset = 1'b0;
        #1;
        check("hr_rv0", {31'b0, resp_valid_0}, 32'd0);
        check("hr_busy", {31'b0, busy}, 32'd0);
        check("hr_data", resp_data, 32'd0);
        tick();
        nreset = 1'b1;
        tick();
        check("hr_after_rv0", {31'b0, resp_valid_0}, 32'd0);
        check("hr_after_busy", {31'b0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/raifes_alu_arbiter.md
RAIFES_ALU_ARBITER -- requirements
Module: raifes_alu_arbiter

Interface
REQ-001 SHALL have no parameters; widths come from the shared headers: XPR_LEN = 32, ALU_OP_WIDTH per ALU op header.
REQ-002 SHALL provide: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL provide: nreset  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide, per requester i in {0,1}: req_valid_i  input  1  request present.
REQ-005 SHALL provide: req_ready_i  output  1  request accepted this cycle.
REQ-006 SHALL provide: req_op_i  input  ALU_OP_WIDTH  ALU operation code.
REQ-007 SHALL provide: req_in1_i  input  32  A operand.
REQ-008 SHALL provide: req_in2_i  input  32  B operand.
REQ-009 SHALL provide: resp_valid_i  output  1  result for requester i held.
REQ-010 SHALL provide: resp_ready_i  input  1  requester i consumes result.
REQ-011 SHALL provide: resp_data  output  32  registered ALU result, shared by both requesters.
REQ-012 SHALL provide: busy  output  1  result slot occupied.

Function
REQ-013 SHALL share one ALU between two requesters, one operation accepted per cycle at most.
REQ-014 SHALL use states IDLE (slot empty) and HOLD (result registered, owner recorded).
REQ-015 IDLE: if any req_valid, SHALL grant exactly one, assert only its req_ready combinationally, register ALU result and owner, then go to HOLD.
REQ-016 HOLD: SHALL assert resp_valid of owner only; resp_data stable until handshake.
REQ-017 HOLD with owner resp_ready=1: SHALL free the slot and may grant a new request in the same cycle (back-to-back, no bubble); stays HOLD if granted, else IDLE.
REQ-018 HOLD with resp_ready=0: SHALL keep both req_ready low; no request dropped or reordered.
REQ-019 Latency SHALL be 1 cycle: accept at edge N, resp_valid high after edge N.
REQ-020 resp_ready of non-owner SHALL be ignored.
REQ-021 Unknown op codes SHALL yield result 0 (ALU default), no error flag.
REQ-022 A requester SHALL hold req_* stable while req_valid=1 and req_ready=0; the arbiter need not check this.
REQ-023 busy SHALL equal (state == HOLD).

Reset
REQ-024 nreset low SHALL asynchronously force IDLE, resp_valid_0/1=0, req_ready_0/1=0, busy=0, resp_data=0, priority pointer = requester 0.
REQ-025 Reset during HOLD SHALL discard the pending result without a response.

Configuration
REQ-026 Macro RAIFES_ALU_ARB_RR_EN defined: round-robin, the requester not granted last wins on contention; pointer updates on every grant.
REQ-027 Macro undefined: fixed priority, requester 0 always wins contention; pointer logic absent.

Structure
REQ-028 State encoding and requester-index constants SHALL live in the shared ALU ops header alongside the ALU_OP_* codes.
REQ-029 SHALL instantiate exactly one sub-module, raifes_alu, fed by the granted requester's op/in1/in2 mux.

Verification
REQ-030 Single request: req0 ADD 5+7 -> req_ready_0 same cycle, next cycle resp_valid_0=1, resp_data=12.
REQ-031 Contention, RR build: both valid from reset, req0 SUB 10-3 and req1 XOR F0^0F -> grants 0 then 1; results 7 then FF to the correct owner.
REQ-032 Contention, fixed build: req0 valid continuously with resp_ready_0=1, req1 valid -> req1 never granted while req0 valid.
REQ-033 Back-pressure: resp_ready_0=0 for 3 cycles with req1 pending -> req_ready_1 low, resp_data stable; on release req1 granted same cycle, no bubble.
REQ-034 Reset in HOLD: SLT 0xFFFFFFFF<1 pending, nreset pulsed low -> resp_valid_0 drops immediately, busy=0, no response after reset.
REQ-035 Unknown op 0x1F -> resp_data=0.
